dualport_be_ram: RTL and testbench

- Simple dual-port synchronous RAM: one write port, one read port, single clock.
- Adds to the basic single-port RAM:
  - per-lane byte enables
  - selectable read latency (1 or 2)
  - defined read-during-write behaviour
  - hardware memory-clear sequencer, run after reset and on request
- General storage element for buffers and register files in the datapath.

---
 rtl/ram_pkg.sv | 38 +++
 rtl/ram_clear_seq.sv | 55 +++++
 rtl/dualport_be_ram.sv | 150 +++++++++++++++
 tb/tb_dualport_be_ram.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and the lane-merge helper for dualport_be_ram.
// Exports rdw_mode_e, ram_state_e, word_t/lanes_t and lane_merge().
package ram_pkg;

  localparam int MAX_DW    = 256;
  localparam int MAX_LANES = 256;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } ram_state_e;

  typedef logic [MAX_DW-1:0]    word_t;
  typedef logic [MAX_LANES-1:0] lanes_t;

  // Bit i comes from new_w when the lane owning bit i is enabled.
  // Callers zero-extend into word_t and truncate the result back.
  function automatic word_t lane_merge(
    input word_t  old_w,
    input word_t  new_w,
    input lanes_t be,
    input int     lane_w
  );
    word_t      res;
    logic [7:0] li;
    for (int i = 0; i < MAX_DW; i++) begin
      li     = 8'(i / lane_w);
      res[i] = be[li] ? new_w[i] : old_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks every address writing zero after reset / on clear.
// Ports: clk, rst_n, clear in; clr_we, clr_addr, init_busy out.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  ram_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          // last address written this edge
          if (clr_cnt_q == '1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we    = busy_q;
  assign clr_addr  = clr_cnt_q;
  assign init_busy = busy_q;

endmodule

// File: rtl/dualport_be_ram.sv
// dualport_be_ram: 1W/1R byte-enable RAM, 1/2-cycle read, RDW select.
// Ports: wr_* write port, rd_* read port, clear/init_busy for zeroing.
module dualport_be_ram
  import ram_pkg::*;
#(
  parameter  int ADDR_WIDTH = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int LANE_WIDTH = 8,
  parameter  int RD_LATENCY = 1,
  parameter  int RDW_MODE   = 1,
  localparam int NUM_LANES  = DATA_WIDTH / LANE_WIDTH,
  localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_LANES-1:0]  wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clear,
  output logic                  init_busy
);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("dualport_be_ram: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
    $error("dualport_be_ram: RDW_MODE must be 0 or 1");
  end
  if (LANE_WIDTH < 1 || DATA_WIDTH % LANE_WIDTH != 0
      || DATA_WIDTH > MAX_DW) begin : g_bad_dw
    $error("dualport_be_ram: bad DATA_WIDTH/LANE_WIDTH");
  end

  localparam rdw_mode_e RDW_E = (RDW_MODE == 1) ? RDW_NEW : RDW_OLD;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy;

  ram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (busy)
  );

  assign init_busy = busy;

  logic wr_go;
  logic rd_go;

  assign wr_go = rst_n & wr_en & ~busy & (|wr_be);
  assign rd_go = rst_n & rd_en & ~busy;

  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_raw;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_old    = mem_q[wr_addr];
  assign wr_merged = DATA_WIDTH'(lane_merge(
                       MAX_DW'(wr_old),
                       MAX_DW'(wr_data),
                       MAX_LANES'(wr_be),
                       LANE_WIDTH));

  // Clear sequencer owns the array port while busy.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_merged;
    if (rst_n && clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (wr_go) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Same-address bypass returns the merged word in NEW mode.
  assign rd_raw  = mem_q[rd_addr];
  assign rd_word = (RDW_E == RDW_NEW && wr_go
                    && wr_addr == rd_addr) ? wr_merged : rd_raw;

  logic                  out_v_d;
  logic [DATA_WIDTH-1:0] out_dat_d;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s1_v_q;
    logic [DATA_WIDTH-1:0] s1_dat_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_v_q   <= 1'b0;
        s1_dat_q <= '0;
      end else begin
        s1_v_q <= rd_go;
        if (rd_go) begin
          s1_dat_q <= rd_word;
        end
      end
    end

    assign out_v_d   = s1_v_q;
    assign out_dat_d = s1_dat_q;
  end else begin : g_lat1
    assign out_v_d   = rd_go;
    assign out_dat_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= out_v_d;
      if (out_v_d) begin
        rd_data_q <= out_dat_d;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_dualport_be_ram.sv
// tb_dualport_be_ram: two RAM instances (lat1/NEW, lat2/OLD), table plus
// random stimulus checked against an array-based reference model.
module tb_dualport_be_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        clear;

  logic [15:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;
  logic        busy1, busy2;

  always #5 clk = ~clk;

  dualport_be_ram #(
    .ADDR_WIDTH (4), .DATA_WIDTH (16), .LANE_WIDTH (8),
    .RD_LATENCY (1), .RDW_MODE (1)
  ) dut1 (
    .clk (clk), .rst_n (rst_n),
    .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_data (wr_data), .wr_be (wr_be),
    .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data1), .rd_valid (rd_valid1),
    .clear (clear), .init_busy (busy1)
  );

  dualport_be_ram #(
    .ADDR_WIDTH (4), .DATA_WIDTH (16), .LANE_WIDTH (8),
    .RD_LATENCY (2), .RDW_MODE (0)
  ) dut2 (
    .clk (clk), .rst_n (rst_n),
    .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_data (wr_data), .wr_be (wr_be),
    .rd_en (rd_en), .rd_addr (rd_addr),
    .rd_data (rd_data2), .rd_valid (rd_valid2),
    .clear (clear), .init_busy (busy2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: plain array, busy countdown, result delay line.
  logic [15:0] mmem [16];
  bit          m_busy;
  int          m_cnt;
  bit          e1v, e2v, s_v;
  logic [15:0] e1d, e2d, s_d;

  function automatic logic [15:0] bmerge(input logic [15:0] o,
                                         input logic [15:0] n,
                                         input logic [1:0]  be);
    logic [15:0] r;
    r = o;
    if (be[0]) r[7:0]  = n[7:0];
    if (be[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  task automatic model_edge();
    bit          rv;
    logic [15:0] r_new, r_old;
    rv    = 1'b0;
    r_new = '0;
    r_old = '0;
    if (!rst_n) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      e1v = 1'b0; e1d = '0;
      e2v = 1'b0; e2d = '0;
      s_v = 1'b0; s_d = '0;
      return;
    end
    if (m_busy) begin
      mmem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == 16) m_busy = 1'b0;
    end else begin
      if (rd_en) begin
        rv    = 1'b1;
        r_old = mmem[rd_addr];
        r_new = r_old;
        if (wr_en && wr_addr == rd_addr)
          r_new = bmerge(r_old, wr_data, wr_be);
      end
      if (wr_en)
        mmem[wr_addr] = bmerge(mmem[wr_addr], wr_data, wr_be);
      if (clear) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    e1v = rv;
    if (rv) e1d = r_new;
    e2v = s_v;
    if (s_v) e2d = s_d;
    s_v = rv;
    if (rv) s_d = r_old;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy1",  16'(busy1),     16'(m_busy));
    chk("busy2",  16'(busy2),     16'(m_busy));
    chk("valid1", 16'(rd_valid1), 16'(e1v));
    chk("valid2", 16'(rd_valid2), 16'(e2v));
    chk("data1",  rd_data1,       e1d);
    chk("data2",  rd_data2,       e2d);
  endtask

  task automatic idle_in();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 0; rd_addr = '0; clear = 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(a);
      step();
      chk("rdall_v", 16'(rd_valid1), 16'd1);
      chk("rdall_d", rd_data1, 16'h0000);
    end
    rd_en = 1'b0;
    step();
    step();
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    bit          re;
    logic [3:0]  ra;
    logic [15:0] e_new;
    logic [15:0] e_old;
  } vec_t;

  function automatic vec_t mk(bit we, logic [3:0] wa, logic [15:0] wd,
                              logic [1:0] be, bit re, logic [3:0] ra,
                              logic [15:0] en, logic [15:0] eo);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.be = be;
    v.re = re; v.ra = ra; v.e_new = en; v.e_old = eo;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [19];
    int   n;

    tbl[0]  = mk(1, 3, 16'hABCD, 2'b11, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 16'h1234, 2'b01, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,        2'b00, 1, 3, 16'hAB34, 16'hAB34);
    tbl[3]  = mk(1, 5, 16'h1111, 2'b11, 0, 0, 0, 0);
    tbl[4]  = mk(1, 5, 16'h2222, 2'b10, 1, 5, 16'h2211, 16'h1111);
    tbl[5]  = mk(0, 0, 0,        2'b00, 1, 5, 16'h2211, 16'h2211);
    tbl[6]  = mk(1, 0, 16'h0010, 2'b11, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 16'h0011, 2'b11, 0, 0, 0, 0);
    tbl[8]  = mk(1, 2, 16'h0012, 2'b11, 0, 0, 0, 0);
    tbl[9]  = mk(1, 3, 16'h0013, 2'b11, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,        2'b00, 1, 0, 16'h0010, 16'h0010);
    tbl[11] = mk(0, 0, 0,        2'b00, 1, 1, 16'h0011, 16'h0011);
    tbl[12] = mk(0, 0, 0,        2'b00, 1, 2, 16'h0012, 16'h0012);
    tbl[13] = mk(0, 0, 0,        2'b00, 1, 3, 16'h0013, 16'h0013);
    tbl[14] = mk(0, 0, 0,        2'b00, 1, 3, 16'h0013, 16'h0013);
    tbl[15] = mk(1, 3, 16'h00FF, 2'b11, 0, 0, 0, 0);
    tbl[16] = mk(1, 6, 16'hBEEF, 2'b11, 1, 2, 16'h0012, 16'h0012);
    tbl[17] = mk(0, 0, 0,        2'b00, 1, 6, 16'hBEEF, 16'hBEEF);
    tbl[18] = mk(1, 7, 16'hFFFF, 2'b00, 1, 7, 16'h0000, 16'h0000);

    for (int a = 0; a < 16; a++) mmem[a] = '0;
    idle_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // user traffic while the init sweep runs must be dropped
    wr_en = 1; wr_addr = 7; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1; rd_addr = 7;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      step();
    end
    idle_in();
    chk("init_window", 16'(n), 16'd16);
    read_all();

    step();
    for (int i = 0; i < 19; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd; wr_be = tbl[i].be;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra;
      step();
      chk("tbl_v1", 16'(rd_valid1), 16'(tbl[i].re));
      if (tbl[i].re) chk("tbl_d1", rd_data1, tbl[i].e_new);
      if (i > 0) begin
        chk("tbl_v2", 16'(rd_valid2), 16'(tbl[i-1].re));
        if (tbl[i-1].re) chk("tbl_d2", rd_data2, tbl[i-1].e_old);
      end
    end
    idle_in();
    step();
    chk("tbl_v2", 16'(rd_valid2), 16'(tbl[18].re));
    chk("tbl_d2", rd_data2, tbl[18].e_old);

    for (int c = 0; c < 400; c++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom);
      wr_data = 16'($urandom);
      wr_be   = 2'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      clear   = ($urandom_range(0, 49) == 0);
      step();
    end
    idle_in();
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      step();
    end

    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_addr = 4'(a);
      wr_data = 16'($urandom) | 16'h0101; wr_be = 2'b11;
      step();
    end
    idle_in();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      clear = (n == 5);
      step();
    end
    clear = 1'b0;
    chk("clr_window", 16'(n), 16'd16);
    read_all();

    clear = 1'b1;
    step();
    clear = 1'b0;
    n = 0;
    while (busy1 && n < 8) begin
      n++;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      step();
    end
    chk("rst_window", 16'(n), 16'd16);
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
